// File: rtl/blvds_frame_tx.sv
// blvds_frame_tx
//   Half-duplex Bus-LVDS link transmitter. Takes one DATA_W word per frame and
//   serialises it onto the shared differential link through the bidirectional
//   pad wrapper. The block owns bus turnaround: it enables the pad driver, sends
//   a lead-in, start bit, data (LSB first), optional even parity, stop bit and
//   trailer, then releases the line.
//
// Ports
//   i_clk        system clock, all logic on the rising edge
//   i_reset_n    synchronous reset, active low
//   i_tx_data    word to send, captured on accept
//   i_tx_valid   word available
//   o_tx_ready   block can accept a word this cycle (combinational)
//   i_rx_busy    remote activity seen by the receiver; defers a new frame
//   o_doutp      serial data to the pad wrapper
//   o_oe         pad driver enable (1 = this end drives the link)
//   o_busy       frame in progress
//   o_tx_done    one-cycle pulse on the cycle after the last bit period
module blvds_frame_tx #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned LEAD_BITS  = 2,
    parameter int unsigned TRAIL_BITS = 1,
    parameter bit          PARITY_EN  = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [DATA_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    input  logic              i_rx_busy,
    output logic              o_doutp,
    output logic              o_oe,
    output logic              o_busy,
    output logic              o_tx_done
);

    localparam int unsigned MAX_BITS =
        (DATA_W >= LEAD_BITS && DATA_W >= TRAIL_BITS) ? DATA_W :
        ((LEAD_BITS >= TRAIL_BITS) ? LEAD_BITS : TRAIL_BITS);
    localparam int unsigned CNT_W = $clog2(MAX_BITS + 1);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LEAD_LAST  = CNT_W'(LEAD_BITS - 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] TRAIL_LAST = CNT_W'((TRAIL_BITS != 0) ? (TRAIL_BITS - 1) : 0);

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StStart,
        StData,
        StParity,
        StStop,
        StTrail
    } state_e;

    state_e              r_state;
    logic [DIV_W-1:0]    r_timer;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic                r_par;
    logic                r_done;

    state_e              w_state_d;
    logic [DIV_W-1:0]    w_timer_d;
    logic [CNT_W-1:0]    w_cnt_d;
    logic [DATA_W-1:0]   w_shift_d;
    logic                w_par_d;
    logic                w_done_d;
    logic                w_accept;
    logic                w_bit_end;

    assign o_tx_ready = (r_state == StIdle) & ~i_rx_busy & i_reset_n;
    assign w_accept   = i_tx_valid & o_tx_ready;
    assign w_bit_end  = (r_timer == '0);

    // Next-state logic. r_cnt holds the number of bits still to go in the
    // current multi-bit state after the one in progress.
    always_comb begin
        w_state_d = r_state;
        w_timer_d = r_timer;
        w_cnt_d   = r_cnt;
        w_shift_d = r_shift;
        w_par_d   = r_par;
        w_done_d  = 1'b0;

        if (r_state == StIdle) begin
            if (w_accept) begin
                w_state_d = StLead;
                w_timer_d = DIV_LAST;
                w_cnt_d   = LEAD_LAST;
                w_shift_d = i_tx_data;
                w_par_d   = ^i_tx_data;
            end
        end else if (!w_bit_end) begin
            w_timer_d = r_timer - 1'b1;
        end else begin
            w_timer_d = DIV_LAST;
            case (r_state)
                StLead: begin
                    if (r_cnt == '0) begin
                        w_state_d = StStart;
                    end else begin
                        w_cnt_d = r_cnt - 1'b1;
                    end
                end
                StStart: begin
                    w_state_d = StData;
                    w_cnt_d   = DATA_LAST;
                end
                StData: begin
                    w_shift_d = r_shift >> 1;
                    if (r_cnt == '0) begin
                        w_state_d = PARITY_EN ? StParity : StStop;
                    end else begin
                        w_cnt_d = r_cnt - 1'b1;
                    end
                end
                StParity: begin
                    w_state_d = StStop;
                end
                StStop: begin
                    if (TRAIL_BITS != 0) begin
                        w_state_d = StTrail;
                        w_cnt_d   = TRAIL_LAST;
                    end else begin
                        w_state_d = StIdle;
                        w_timer_d = '0;
                        w_cnt_d   = '0;
                        w_done_d  = 1'b1;
                    end
                end
                StTrail: begin
                    if (r_cnt == '0) begin
                        w_state_d = StIdle;
                        w_timer_d = '0;
                        w_done_d  = 1'b1;
                    end else begin
                        w_cnt_d = r_cnt - 1'b1;
                    end
                end
                default: begin
                    w_state_d = StIdle;
                    w_timer_d = '0;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
            r_timer <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_timer <= w_timer_d;
            r_cnt   <= w_cnt_d;
            r_shift <= w_shift_d;
            r_par   <= w_par_d;
            r_done  <= w_done_d;
        end
    end

    // Line is held high everywhere except the start, data and parity bits.
    always_comb begin
        o_doutp = 1'b1;
        case (r_state)
            StStart:  o_doutp = 1'b0;
            StData:   o_doutp = r_shift[0];
            StParity: o_doutp = r_par;
            default:  o_doutp = 1'b1;
        endcase
    end

    assign o_oe      = (r_state != StIdle);
    assign o_busy    = (r_state != StIdle);
    assign o_tx_done = r_done;

endmodule

// File: tb/tb_blvds_frame_tx.sv
module tb_blvds_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        rx_busy;
    logic        tx_valid_a, tx_valid_b;
    logic [7:0]  tx_data_a;
    logic [15:0] tx_data_b;
    logic        tx_ready_a, doutp_a, oe_a, busy_a, tx_done_a;
    logic        tx_ready_b, doutp_b, oe_b, busy_b, tx_done_b;
    logic        rx_busy_b;

    // Main configuration: 8-bit payload, 4 clocks per bit, parity, one trailer bit.
    blvds_frame_tx #(
        .DATA_W(8), .CLK_DIV(4), .LEAD_BITS(2), .TRAIL_BITS(1), .PARITY_EN(1'b1)
    ) dut_a (
        .i_clk(clk), .i_reset_n(reset_n), .i_tx_data(tx_data_a), .i_tx_valid(tx_valid_a),
        .o_tx_ready(tx_ready_a), .i_rx_busy(rx_busy), .o_doutp(doutp_a), .o_oe(oe_a),
        .o_busy(busy_a), .o_tx_done(tx_done_a)
    );

    // Minimal configuration: one clock per bit, no parity, no trailer.
    blvds_frame_tx #(
        .DATA_W(16), .CLK_DIV(1), .LEAD_BITS(2), .TRAIL_BITS(0), .PARITY_EN(1'b0)
    ) dut_b (
        .i_clk(clk), .i_reset_n(reset_n), .i_tx_data(tx_data_b), .i_tx_valid(tx_valid_b),
        .o_tx_ready(tx_ready_b), .i_rx_busy(rx_busy_b), .o_doutp(doutp_b), .o_oe(oe_b),
        .o_busy(busy_b), .o_tx_done(tx_done_b)
    );

    // Expected line bits, leftmost = first transmitted.
    typedef struct {
        logic [13:0] bits;
        int unsigned gap;   // required idle cycles before this frame, 0 = any
    } exp_a_t;

    exp_a_t      qa[$];
    logic [19:0] qb[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    bit          abort_pending = 1'b0;
    int          frames_a = 0;
    int          frames_b = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor for dut_a: captures the line while oe is high and scores each frame.
    logic        prev_oe_a = 1'b0;
    int          run_a = 0;
    int          low_a = 1000;
    logic        samp_a [64];

    always @(negedge clk) begin : mon_a
        exp_a_t      e;
        logic [13:0] got;
        bit          cons;
        if (mon_en) begin
            chk("done_a", {31'd0, tx_done_a}, {31'd0, prev_oe_a && !oe_a && !abort_pending});
            if (oe_a && !prev_oe_a) begin
                if (qa.size() == 0) chk("unexpected_frame_a", 32'd1, 32'd0);
                else if (qa[0].gap != 0) chk("gap_a", low_a, qa[0].gap);
                run_a = 0;
            end
            if (oe_a) begin
                if (run_a < 64) samp_a[run_a] = doutp_a;
                run_a++;
            end else begin
                if (prev_oe_a) begin
                    if (abort_pending) begin
                        abort_pending = 1'b0;
                        if (qa.size() > 0) e = qa.pop_front();
                        chk("abort_busy_a", {31'd0, busy_a}, 32'd0);
                    end else if (qa.size() == 0) begin
                        chk("unexpected_end_a", 32'd1, 32'd0);
                    end else begin
                        e = qa.pop_front();
                        frames_a++;
                        chk("oe_len_a", run_a, 32'd56);
                        got  = '0;
                        cons = 1'b1;
                        for (int k = 0; k < 14; k++) begin
                            got[13-k] = samp_a[k*4];
                            for (int j = 1; j < 4; j++)
                                if (samp_a[k*4+j] !== samp_a[k*4]) cons = 1'b0;
                        end
                        chk("bits_a", {18'd0, got}, {18'd0, e.bits});
                        chk("bit_hold_a", {31'd0, cons}, 32'd1);
                    end
                    low_a = 1;
                end else begin
                    low_a++;
                end
                chk("idle_dout_a", {31'd0, doutp_a}, 32'd1);
            end
            prev_oe_a = oe_a;
        end
    end

    // Monitor for dut_b: one clock per bit.
    logic        prev_oe_b = 1'b0;
    int          run_b = 0;
    logic        samp_b [32];

    always @(negedge clk) begin : mon_b
        logic [19:0] got;
        logic [19:0] want;
        if (mon_en) begin
            chk("done_b", {31'd0, tx_done_b}, {31'd0, prev_oe_b && !oe_b});
            if (oe_b && !prev_oe_b) begin
                if (qb.size() == 0) chk("unexpected_frame_b", 32'd1, 32'd0);
                run_b = 0;
            end
            if (oe_b) begin
                if (run_b < 32) samp_b[run_b] = doutp_b;
                run_b++;
            end else begin
                if (prev_oe_b && qb.size() > 0) begin
                    want = qb.pop_front();
                    frames_b++;
                    chk("oe_len_b", run_b, 32'd20);
                    got = '0;
                    for (int k = 0; k < 20; k++) got[19-k] = samp_b[k];
                    chk("bits_b", {12'd0, got}, {12'd0, want});
                end
                chk("idle_dout_b", {31'd0, doutp_b}, 32'd1);
            end
            prev_oe_b = oe_b;
        end
    end

    // Presents a word on dut_a, records its expected frame once accepted, and
    // returns at the negedge following the accepting clock edge.
    task automatic issue_a(input logic [7:0] w, input logic [13:0] bits, input int unsigned gap);
        int     n;
        exp_a_t e;
        tx_valid_a = 1'b1;
        tx_data_a  = w;
        #1;
        n = 0;
        while (!tx_ready_a && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!tx_ready_a) begin
            chk("accept_timeout_a", 32'd0, 32'd1);
        end else begin
            e.bits = bits;
            e.gap  = gap;
            qa.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        @(negedge clk);
        while (busy_a && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy_a) chk("idle_timeout_a", 32'd1, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n    = 1'b0;
        rx_busy    = 1'b0;
        rx_busy_b  = 1'b0;
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
        tx_data_a  = '0;
        tx_data_b  = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_oe", {31'd0, oe_a}, 32'd0);
        chk("rst_doutp", {31'd0, doutp_a}, 32'd1);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_done", {31'd0, tx_done_a}, 32'd0);
        chk("rst_ready_low", {31'd0, tx_ready_a}, 32'd0);
        reset_n = 1'b1;
        #1;
        chk("ready_after_rst", {31'd0, tx_ready_a}, 32'd1);
        mon_en = 1'b1;
        @(negedge clk);

        // T1 / T2: single frames.
        issue_a(8'hA5, 14'b11_0_10100101_0_1_1, 0);
        tx_valid_a = 1'b0;
        wait_idle_a();
        issue_a(8'h01, 14'b11_0_10000000_1_1_1, 0);
        tx_valid_a = 1'b0;
        wait_idle_a();
        issue_a(8'h00, 14'b11_0_00000000_0_1_1, 0);
        tx_valid_a = 1'b0;
        wait_idle_a();

        // T3: remote activity defers acceptance.
        rx_busy    = 1'b1;
        tx_valid_a = 1'b1;
        tx_data_a  = 8'hC3;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("rxbusy_ready", {31'd0, tx_ready_a}, 32'd0);
            chk("rxbusy_oe", {31'd0, oe_a}, 32'd0);
            @(negedge clk);
        end
        rx_busy = 1'b0;
        #1;
        chk("ready_after_rxbusy", {31'd0, tx_ready_a}, 32'd1);
        if (tx_ready_a) begin
            exp_a_t e;
            e.bits = 14'b11_0_11000011_0_1_1;
            e.gap  = 0;
            qa.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        chk("oe_rise_after_accept", {31'd0, oe_a}, 32'd1);
        tx_valid_a = 1'b0;
        wait_idle_a();

        // T4: back-to-back words with valid held high.
        issue_a(8'h3C, 14'b11_0_00111100_0_1_1, 0);
        issue_a(8'h13, 14'b11_0_11001000_1_1_1, 1);
        issue_a(8'h81, 14'b11_0_10000001_0_1_1, 1);
        tx_valid_a = 1'b0;
        wait_idle_a();

        // T5: reset during data bit 3 (cycles 24..27 of the frame).
        issue_a(8'hE7, 14'b11_0_11100111_0_1_1, 0);
        tx_valid_a = 1'b0;
        repeat (25) @(negedge clk);
        abort_pending = 1'b1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_oe", {31'd0, oe_a}, 32'd0);
        chk("abort_doutp", {31'd0, doutp_a}, 32'd1);
        chk("abort_busy", {31'd0, busy_a}, 32'd0);
        chk("abort_done", {31'd0, tx_done_a}, 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        issue_a(8'h5A, 14'b11_0_01011010_0_1_1, 0);
        tx_valid_a = 1'b0;
        wait_idle_a();

        // T6: minimal configuration, all-ones payload.
        tx_valid_b = 1'b1;
        tx_data_b  = 16'hFFFF;
        #1;
        n = 0;
        while (!tx_ready_b && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!tx_ready_b) chk("accept_timeout_b", 32'd0, 32'd1);
        else qb.push_back(20'b11_0_1111111111111111_1);
        @(posedge clk);
        @(negedge clk);
        tx_valid_b = 1'b0;
        n = 0;
        while (busy_b && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy_b) chk("idle_timeout_b", 32'd1, 32'd0);
        repeat (3) @(negedge clk);

        chk("frames_a", frames_a, 32'd8);
        chk("frames_b", frames_b, 32'd1);
        chk("queue_a_empty", qa.size(), 32'd0);
        chk("queue_b_empty", qb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
